// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Byte FIFO plus start_tx/tx_done four-phase sequencer feeding the UART
//   transmitter. The CPU side pushes bytes with single-cycle strobes. The
//   sequencer pops one byte at a time into tx_value and holds start_tx high
//   until the transmitter acknowledges with tx_done.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   wr_en        in   push strobe
//   wr_data      in   byte to push
//   full         out  count == DEPTH
//   empty        out  count == 0
//   count        out  bytes stored (excludes the byte in tx_value)
//   overflow     out  sticky, set by a push while full
//   clr_overflow in   clears overflow (a same-cycle dropped push wins)
//   busy         out  sequencer not idle or FIFO not empty
//   start_tx     out  level request to transmitter, high for a whole byte
//   tx_value     out  byte to transmit, changes only on a pop
//   tx_done      in   transmitter acknowledge
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic                  busy,
    output logic                  start_tx,
    output logic [7:0]            tx_value,
    input  logic                  tx_done
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_RELEASE
    } state_t;

    state_t                state_q;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  start_tx_q;
    logic [7:0]            tx_value_q;

    logic push, drop, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // full is taken from the registered count, so a pop in the same cycle
    // never makes room for a push that arrives while full.
    assign push = wr_en && !full;
    assign drop = wr_en && full;
    assign pop  = (state_q == S_IDLE) && !empty;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A dropped push takes priority over a clear in the same cycle.
        if (drop)
            overflow_d = 1'b1;
        else if (clr_overflow)
            overflow_d = 1'b0;
        else
            overflow_d = overflow_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array carries no reset; its contents are only ever read
    // behind a valid count.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem_q[wr_ptr_q] <= wr_data;
    end

    // Handshake sequencer. tx_value and start_tx are loaded together on the
    // pop so the transmitter never sees start_tx with a stale byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            start_tx_q <= 1'b0;
            tx_value_q <= 8'h00;
            rd_ptr_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        tx_value_q <= mem_q[rd_ptr_q];
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        start_tx_q <= 1'b1;
                        state_q    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_done) begin
                        start_tx_q <= 1'b0;
                        state_q    <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!tx_done)
                        state_q <= S_IDLE;
                end
                default: begin
                    start_tx_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign start_tx = start_tx_q;
    assign tx_value = tx_value_q;
    assign busy     = (state_q != S_IDLE) || !empty;

endmodule
